seq_muldiv: RTL
===============

# seq_muldiv

Parametrised sequential integer multiply/divide unit for the datapath. It takes two WIDTH-bit operands and computes either a 2·WIDTH-bit product or a quotient/remainder pair. Operation is selected per request as signed or unsigned, multiply or divide. It iterates one bit per clock through a shared WIDTH-bit adder, behind a start/busy/valid handshake, and generalises the existing fixed 32-bit shift-add multiplier.

## Interface
- WIDTH, 32, operand width; legal values are 8 to 64.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only while busy=0.
- muordi  input  1  0 = multiply, 1 = divide.
- sign_en  input  1  1 = operands are two's complement, 0 = unsigned.
- opera1  input  WIDTH  multiplicand / dividend.
- opera2  input  WIDTH  multiplier / divisor.
- busy  output  1  high from request acceptance until valid.
- valid  output  1  one-cycle pulse when result is updated.
- result  output  2·WIDTH  multiply: product; divide: {remainder, quotient}.
- div_by_zero  output  1  set with valid when divide had opera2=0.

## Operation
- Reset (reset=0) forces all outputs to 0: busy=0, valid=0, result=0, div_by_zero=0. The FSM goes to IDLE and the iteration counter clears. This happens immediately, mid-operation included; the aborted request never produces valid.
- FSM states: IDLE → PREP → ITER → FIX → IDLE.
- IDLE, start=1: latch opera1, opera2, muordi, sign_en; busy=1; go to PREP. Inputs may change after acceptance.
- PREP (1 cycle): if sign_en, take magnitudes of negative operands via adder (invert, +1) and record result sign. For divide, record remainder sign = dividend sign. Divide with divisor 0 → FIX directly. Otherwise clear counter → ITER.
- ITER (exactly WIDTH cycles):
  - Multiply: right-shift add. If the accumulator LSB is 1, add the multiplicand to the upper half; then shift the {carry, acc} pair right 1.
  - Divide: restoring. Shift {rem, quo} left 1, trial-subtract the divisor, keep on no borrow, set quo LSB.
- FIX (1 cycle): negate product if signs differ (signed only). Negate quotient if signs differ. Negate remainder if dividend was negative. Drive result, then valid=1, busy=0 → IDLE.
- Arithmetic rules:
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
  - MIN / −1 yields quotient = MIN (wrap), remainder 0, no flag.
- Divide by zero: quotient = all ones, remainder = opera1 unmodified, div_by_zero=1. Both signed and unsigned follow this rule.
- div_by_zero is valid only in the valid cycle. It returns to 0 on the next accepted start.
- result holds its value until the next valid or reset.
- start while busy=1 is ignored (no queueing).

## Timing
- Start sampled high at edge E0 (in IDLE) → busy=1 after E0.
- Normal latency: valid=1 after edge E0+WIDTH+2, for exactly one cycle; busy falls at the same edge.
- Divide by zero: valid after E0+2.
- Back-to-back: start=1 during the valid cycle is accepted at that edge. Throughput is one operation per WIDTH+2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- MULDIV_DIV_EN defined: divide path, divisor register, and div_by_zero logic are compiled in, as described above.
- MULDIV_DIV_EN undefined:
  - muordi is ignored and every request is a multiply with identical latency.
  - div_by_zero is tied 0.
  - Area is multiply-only.

## Test plan
- WIDTH=32, unsigned multiply 0xFFFFFFFF × 0xFFFFFFFF → result=0xFFFFFFFE00000001; valid pulse one cycle after E0+34.
- Signed multiply 7 × 0xFFFFFFFD (−3) → result=0xFFFFFFFFFFFFFFEB. Repeat with sign_en=0 → result=0x00000006FFFFFFEB.
- Signed divide 0xFFFFFFF9 (−7) ÷ 2 → result=0xFFFFFFFF_FFFFFFFD (r=−1, q=−3). Signed 0x80000000 ÷ 0xFFFFFFFF → result=0x00000000_80000000, div_by_zero=0.
- Divide 100 ÷ 0 → result=0x00000064_FFFFFFFF, div_by_zero=1, valid after E0+2. Next multiply clears div_by_zero.
- Assert reset low at E0+10 mid-multiply → all outputs 0 immediately, no valid. After reset release, new start completes normally. Start pulsed while busy → ignored, single valid.
- Build without MULDIV_DIV_EN, muordi=1, 3 × 5 → result=15, valid after E0+34, div_by_zero=0.

Source files
------------

// File: rtl/seq_muldiv.sv
// seq_muldiv: sequential signed/unsigned multiply (and optional divide, MULDIV_DIV_EN), one bit per clock.
// Latency: valid WIDTH+2 edges after the accepting edge; divide by zero completes in 2.
// Backpressure: busy high while an operation is in flight; start is ignored while busy.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 muordi,
  input  logic                 sign_en,
  input  logic [WIDTH-1:0]     opera1,
  input  logic [WIDTH-1:0]     opera2,
  output logic                 busy,
  output logic                 valid,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi;       // product upper half / partial remainder
  logic [WIDTH-1:0] lo;       // multiplier bits / quotient bits
  logic             op_sign;
  logic             neg_res;  // product or quotient must be negated in FIX
  logic             neg_rem;  // remainder must be negated in FIX
  logic             zdiv;     // divide with zero divisor in flight
  logic             op_div;

`ifdef MULDIV_DIV_EN
  logic op_div_q;
  assign op_div = op_div_q;
`else
  // Multiply-only build: the divide select is accepted but has no effect.
  logic unused_muordi;
  assign op_div        = 1'b0;
  assign unused_muordi = muordi;
`endif

  // Operand sign detection for magnitude conversion in PREP.
  logic neg1, neg2;
  assign neg1 = op_sign & lo[WIDTH-1];
  assign neg2 = op_sign & a[WIDTH-1];

  // Shared WIDTH-bit adder: add-multiplicand for multiply, trial subtract for divide.
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_ci;
  logic [WIDTH:0]   add_s;
  logic             no_borrow;
  always_comb begin
    if (op_div) begin
      add_x  = {hi[WIDTH-2:0], lo[WIDTH-1]};
      add_y  = ~a;
      add_ci = 1'b1;
    end else begin
      add_x  = hi;
      add_y  = lo[0] ? a : '0;
      add_ci = 1'b0;
    end
    add_s = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
    // The shifted-out remainder MSB makes the trial value exceed any divisor.
    no_borrow = hi[WIDTH-1] | add_s[WIDTH];
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      a           <= '0;
      hi          <= '0;
      lo          <= '0;
      op_sign     <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      zdiv        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q    <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lo          <= opera1;
            a           <= opera2;
            hi          <= '0;
            op_sign     <= sign_en;
            zdiv        <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
`ifdef MULDIV_DIV_EN
            op_div_q    <= muordi;
`endif
            state       <= PREP;
          end
        end
        PREP: begin
          if (op_div && (a == '0)) begin
            // Divide by zero: remainder is the raw dividend, quotient all ones.
            hi    <= lo;
            lo    <= '1;
            zdiv  <= 1'b1;
            state <= FIX;
          end else begin
            lo      <= neg1 ? -lo : lo;
            a       <= neg2 ? -a : a;
            neg_res <= neg1 ^ neg2;
            neg_rem <= neg1;
            cnt     <= '0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (op_div) begin
            if (no_borrow) begin
              hi <= add_s[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {add_s, lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          if (zdiv)
            result <= {hi, lo};
          else if (op_div)
            result <= {(neg_rem ? -hi : hi), (neg_res ? -lo : lo)};
          else
            result <= neg_res ? -{hi, lo} : {hi, lo};
          div_by_zero <= zdiv;
          valid       <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
